// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multicycle control FSM and the
// memory/datapath side. The controller owns the request strobes and the
// address-select; the memory owns the completion signal.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle LEGv8 datapath. Sequences every instruction
// through fetch/decode/execute/memory/writeback over one shared memory port,
// supervises each memory access with a wait counter, latches a sticky fault
// code and counts retired instructions.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op,
    input  logic             alu_zero,
    multicycle_ctrl_if.master bus,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg2loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instr_count
);

    // Wait counter only has to reach TIMEOUT-1 before the trap fires.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        st_fetch,
        st_decode,
        st_mem_addr,
        st_mem_rd,
        st_ld_wb,
        st_mem_wr,
        st_exec_r,
        st_r_wb,
        st_cbz_ex,
        st_b_ex,
        st_trap
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    logic       mem_req_d, mem_read_d, mem_write_d, iord_d;
    logic       ir_write_d, pc_write_d, reg2loc_d, reg_write_d;
    logic       mem_to_reg_d, alu_src_a_d;
    logic [1:0] pc_src_d, alu_src_b_d, alu_op_d;

    function automatic logic is_ldur(input logic [10:0] o);
        return o == 11'h7C2;
    endfunction

    function automatic logic is_stur(input logic [10:0] o);
        return o == 11'h7C0;
    endfunction

    // CBZ occupies 5A0..5A7: the low three bits carry Rt-independent encoding.
    function automatic logic is_cbz(input logic [10:0] o);
        return o[10:3] == 8'hB4;
    endfunction

    // B occupies 0A0..0BF: only the top six bits are fixed.
    function automatic logic is_b(input logic [10:0] o);
        return o[10:5] == 6'h05;
    endfunction

    function automatic logic is_rtype(input logic [10:0] o);
        return (o == 11'h458) || (o == 11'h658) || (o == 11'h450) || (o == 11'h550);
    endfunction

    // The TIMEOUT-th consecutive not-ready cycle of one access traps.
    assign timeout_hit = (TIMEOUT > 0) && !bus.mem_ready &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Sequencing, access supervision, sticky fault and retire counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= st_fetch;
            wait_cnt    <= '0;
            fault       <= 2'b00;
            instr_count <= '0;
        end else begin
            // Every entry into a memory state starts from a cleared counter.
            wait_cnt <= '0;
            case (state)
                st_fetch: begin
                    if (bus.mem_ready) begin
                        state <= st_decode;
                    end else if (timeout_hit) begin
                        state <= st_trap;
                        fault <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                st_decode: begin
                    if (is_ldur(op) || is_stur(op)) begin
                        state <= st_mem_addr;
                    end else if (is_rtype(op)) begin
                        state <= st_exec_r;
                    end else if (is_cbz(op)) begin
                        state <= st_cbz_ex;
                    end else if (is_b(op)) begin
                        state <= st_b_ex;
                    end else begin
                        state <= st_trap;
                        fault <= 2'b01;
                    end
                end
                st_mem_addr: begin
                    state <= is_ldur(op) ? st_mem_rd : st_mem_wr;
                end
                st_mem_rd: begin
                    if (bus.mem_ready) begin
                        state <= st_ld_wb;
                    end else if (timeout_hit) begin
                        state <= st_trap;
                        fault <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                st_mem_wr: begin
                    if (bus.mem_ready) begin
                        state       <= st_fetch;
                        instr_count <= instr_count + 1'b1;
                    end else if (timeout_hit) begin
                        state <= st_trap;
                        fault <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                st_exec_r: begin
                    state <= st_r_wb;
                end
                st_ld_wb, st_r_wb, st_cbz_ex, st_b_ex: begin
                    state       <= st_fetch;
                    instr_count <= instr_count + 1'b1;
                end
                st_trap: begin
                    state <= st_trap;
                end
                default: begin
                    state <= st_fetch;
                end
            endcase
        end
    end

    // Control decode from state; ir_write/pc_write and the CBZ pc_src follow
    // same-cycle inputs so zero-wait memory and branch resolution cost no cycle.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        ir_write_d   = 1'b0;
        pc_write_d   = 1'b0;
        pc_src_d     = 2'b00;
        reg2loc_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        case (state)
            st_fetch: begin
                mem_req_d  = 1'b1;
                mem_read_d = 1'b1;
                ir_write_d = bus.mem_ready;
            end
            st_decode: begin
                alu_src_b_d = 2'b10;
                reg2loc_d   = is_stur(op) || is_cbz(op);
            end
            st_mem_addr: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b01;
            end
            st_mem_rd: begin
                mem_req_d  = 1'b1;
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            st_ld_wb: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                pc_write_d   = 1'b1;
            end
            st_mem_wr: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
                reg2loc_d   = 1'b1;
                pc_write_d  = bus.mem_ready;
            end
            st_exec_r: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            st_r_wb: begin
                reg_write_d = 1'b1;
                pc_write_d  = 1'b1;
            end
            st_cbz_ex: begin
                reg2loc_d   = 1'b1;
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b01;
                pc_write_d  = 1'b1;
                pc_src_d    = {1'b0, alu_zero};
            end
            st_b_ex: begin
                pc_write_d = 1'b1;
                pc_src_d   = 2'b01;
            end
            default: begin
            end
        endcase
    end

    // Reset masks every control line immediately, even mid-access.
    assign bus.mem_req   = reset & mem_req_d;
    assign bus.mem_read  = reset & mem_read_d;
    assign bus.mem_write = reset & mem_write_d;
    assign bus.iord      = reset & iord_d;
    assign ir_write      = reset & ir_write_d;
    assign pc_write      = reset & pc_write_d;
    assign reg2loc       = reset & reg2loc_d;
    assign reg_write     = reset & reg_write_d;
    assign mem_to_reg    = reset & mem_to_reg_d;
    assign alu_src_a     = reset & alu_src_a_d;
    assign pc_src        = reset ? pc_src_d    : 2'b00;
    assign alu_src_b     = reset ? alu_src_b_d : 2'b00;
    assign alu_op        = reset ? alu_op_d    : 2'b00;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table,
// hand-written multi-cycle corner sequences and a randomized run checked
// against an instruction-level reference model.
module tb_multicycle_ctrl;
    localparam int TO = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg2loc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    typedef struct {
        logic [10:0] op;
        logic        z;
        int          lat;
        logic [1:0]  pcs;
        logic        rw;
        logic        mw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] op = '0;
    logic        alu_zero = 1'b0;
    logic        ir_write, pc_write, reg2loc, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  pc_src, alu_src_b, alu_op, fault;
    logic [31:0] instr_count;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .alu_zero   (alu_zero),
        .bus        (bus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .fault      (fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          npass = 0;
    int          ntotal = 0;
    logic [31:0] exp_count = '0;
    logic [1:0]  exp_fault = 2'b00;
    int          rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready

    function automatic ctl_t actual();
        ctl_t a;
        a.mem_req    = bus.mem_req;
        a.mem_read   = bus.mem_read;
        a.mem_write  = bus.mem_write;
        a.iord       = bus.iord;
        a.ir_write   = ir_write;
        a.pc_write   = pc_write;
        a.pc_src     = pc_src;
        a.reg2loc    = reg2loc;
        a.reg_write  = reg_write;
        a.mem_to_reg = mem_to_reg;
        a.alu_src_a  = alu_src_a;
        a.alu_src_b  = alu_src_b;
        a.alu_op     = alu_op;
        return a;
    endfunction

    function automatic logic [31:0] cw32(input ctl_t c);
        return {16'h0, c};
    endfunction

    function automatic bit m_cbz(input logic [10:0] o);
        return (o >= 11'h5A0) && (o <= 11'h5A7);
    endfunction

    function automatic bit m_b(input logic [10:0] o);
        return (o >= 11'h0A0) && (o <= 11'h0BF);
    endfunction

    function automatic bit m_rtype(input logic [10:0] o);
        return (o == 11'h458) || (o == 11'h658) || (o == 11'h450) || (o == 11'h550);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: apply mem_ready, compare at the falling edge, advance.
    task automatic step(input string name, input ctl_t e, input logic rdy);
        bus.mem_ready = rdy;
        @(negedge clk);
        check(name, cw32(actual()), cw32(e));
        check({name, "/count"}, instr_count, exp_count);
        check({name, "/fault"}, 32'(fault), 32'(exp_fault));
        @(posedge clk);
        #1;
    endtask

    // One memory access: ready per rdy_mode; TO not-ready cycles end in a trap.
    task automatic mem_phase(input string name, input ctl_t base, input bit is_fetch,
                             input bit is_wr, output bit ok);
        ctl_t e;
        logic rdy;
        ok = 1'b0;
        for (int w = 0; w < TO; w++) begin
            case (rdy_mode)
                1:       rdy = 1'b1;
                2:       rdy = 1'b0;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            e = base;
            if (rdy) begin
                e.ir_write = is_fetch;
                e.pc_write = is_wr;
            end
            step(name, e, rdy);
            if (rdy) begin
                if (is_wr) exp_count++;
                ok = 1'b1;
                return;
            end
        end
        exp_fault = 2'b10;
    endtask

    // Reference model for one whole instruction, phase by phase.
    task automatic run_instr(input logic [10:0] o, input logic z, output bit trapped);
        ctl_t e;
        bit ok;
        op = o;
        alu_zero = z;
        trapped = 1'b0;
        e = '0; e.mem_req = 1; e.mem_read = 1;
        mem_phase("fetch", e, 1'b1, 1'b0, ok);
        if (!ok) begin trapped = 1'b1; return; end
        e = '0; e.alu_src_b = 2'b10; e.reg2loc = (o == 11'h7C0) || m_cbz(o);
        step("decode", e, 1'($urandom_range(0, 1)));
        if (o == 11'h7C2 || o == 11'h7C0) begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b01;
            step("mem_addr", e, 1'($urandom_range(0, 1)));
            if (o == 11'h7C2) begin
                e = '0; e.mem_req = 1; e.mem_read = 1; e.iord = 1;
                mem_phase("mem_rd", e, 1'b0, 1'b0, ok);
                if (!ok) begin trapped = 1'b1; return; end
                e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.pc_write = 1;
                step("ld_wb", e, 1'($urandom_range(0, 1)));
                exp_count++;
            end else begin
                e = '0; e.mem_req = 1; e.mem_write = 1; e.iord = 1; e.reg2loc = 1;
                mem_phase("mem_wr", e, 1'b0, 1'b1, ok);
                if (!ok) trapped = 1'b1;
            end
        end else if (m_rtype(o)) begin
            e = '0; e.alu_src_a = 1; e.alu_op = 2'b10;
            step("exec_r", e, 1'($urandom_range(0, 1)));
            e = '0; e.reg_write = 1; e.pc_write = 1;
            step("r_wb", e, 1'($urandom_range(0, 1)));
            exp_count++;
        end else if (m_cbz(o)) begin
            e = '0; e.reg2loc = 1; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write = 1;
            e.pc_src = z ? 2'b01 : 2'b00;
            step("cbz_ex", e, 1'($urandom_range(0, 1)));
            exp_count++;
        end else if (m_b(o)) begin
            e = '0; e.pc_write = 1; e.pc_src = 2'b01;
            step("b_ex", e, 1'($urandom_range(0, 1)));
            exp_count++;
        end else begin
            exp_fault = 2'b01;
            trapped = 1'b1;
        end
    endtask

    task automatic trap_hold(input int n);
        for (int k = 0; k < n; k++) step("trap_hold", '0, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_count = '0;
        exp_fault = 2'b00;
        @(negedge clk);
        check("reset_ctl", cw32(actual()), 32'h0);
        check("reset_count", instr_count, 32'h0);
        check("reset_fault", 32'(fault), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t        tbl[13];
    logic [10:0] rlist[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e;
        bit trapped;
        int cycles;
        logic rw, mw;
        logic [1:0] pcs;
        bit done;

        tbl[0]  = '{11'h458, 1'b0, 4, 2'b00, 1'b1, 1'b0};
        tbl[1]  = '{11'h658, 1'b1, 4, 2'b00, 1'b1, 1'b0};
        tbl[2]  = '{11'h450, 1'b0, 4, 2'b00, 1'b1, 1'b0};
        tbl[3]  = '{11'h550, 1'b0, 4, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{11'h7C2, 1'b0, 5, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{11'h7C0, 1'b0, 4, 2'b00, 1'b0, 1'b1};
        tbl[6]  = '{11'h5A3, 1'b1, 3, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{11'h5A3, 1'b0, 3, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{11'h5A0, 1'b1, 3, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{11'h5A7, 1'b1, 3, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{11'h0B7, 1'b0, 3, 2'b01, 1'b0, 1'b0};
        tbl[11] = '{11'h0A0, 1'b0, 3, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{11'h0BF, 1'b1, 3, 2'b01, 1'b0, 1'b0};
        rlist[0] = 11'h458; rlist[1] = 11'h658; rlist[2] = 11'h450; rlist[3] = 11'h550;

        bus.mem_ready = 1'b0;
        do_reset();

        // zero-wait instruction table: latency, branch select and write activity
        for (int i = 0; i < 13; i++) begin
            op = tbl[i].op;
            alu_zero = tbl[i].z;
            bus.mem_ready = 1'b1;
            cycles = 0; rw = 0; mw = 0; pcs = 2'b11; done = 0;
            for (int c = 1; c <= 8 && !done; c++) begin
                @(negedge clk);
                rw |= reg_write;
                mw |= bus.mem_write;
                if (pc_write) begin
                    done = 1;
                    cycles = c;
                    pcs = pc_src;
                end
                @(posedge clk);
                #1;
            end
            check("tbl_latency", 32'(cycles), 32'(tbl[i].lat));
            check("tbl_pc_src", 32'(pcs), 32'(tbl[i].pcs));
            check("tbl_reg_write", 32'(rw), 32'(tbl[i].rw));
            check("tbl_mem_write", 32'(mw), 32'(tbl[i].mw));
            check("tbl_count", instr_count, 32'(i + 1));
        end
        exp_count = 32'd13;

        // LDUR with three not-ready cycles in the data read
        op = 11'h7C2; alu_zero = 1'b0;
        e = '0; e.mem_req = 1; e.mem_read = 1; e.ir_write = 1;
        step("ld_fetch", e, 1'b1);
        e = '0; e.alu_src_b = 2'b10;
        step("ld_decode", e, 1'b0);
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b01;
        step("ld_addr", e, 1'b1);
        e = '0; e.mem_req = 1; e.mem_read = 1; e.iord = 1;
        for (int k = 0; k < 3; k++) step("ld_rd_wait", e, 1'b0);
        step("ld_rd_done", e, 1'b1);
        e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.pc_write = 1;
        step("ld_wb_cycle8", e, 1'b0);
        exp_count++;

        // fetch never ready: trap after TO request cycles
        rdy_mode = 2;
        run_instr(11'h458, 1'b0, trapped);
        check("timeout_trapped", 32'(trapped), 32'h1);
        trap_hold(3);
        do_reset();

        // ready on the last allowed cycle proceeds normally
        op = 11'h458;
        e = '0; e.mem_req = 1; e.mem_read = 1;
        for (int k = 0; k < TO - 1; k++) step("to_edge_wait", e, 1'b0);
        e.ir_write = 1;
        step("to_edge_ready", e, 1'b1);
        e = '0; e.alu_src_b = 2'b10;
        step("to_edge_decode", e, 1'b0);
        e = '0; e.alu_src_a = 1; e.alu_op = 2'b10;
        step("to_edge_exec", e, 1'b0);
        e = '0; e.reg_write = 1; e.pc_write = 1;
        step("to_edge_wb", e, 1'b0);
        exp_count++;

        // illegal opcode traps and stays silent
        rdy_mode = 1;
        run_instr(11'h000, 1'b0, trapped);
        check("illegal_trapped", 32'(trapped), 32'h1);
        trap_hold(20);
        do_reset();

        // reset asserted in the middle of a store
        run_instr(11'h458, 1'b0, trapped);
        op = 11'h7C0;
        e = '0; e.mem_req = 1; e.mem_read = 1; e.ir_write = 1;
        step("st_fetch", e, 1'b1);
        e = '0; e.alu_src_b = 2'b10; e.reg2loc = 1;
        step("st_decode", e, 1'b1);
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b01;
        step("st_addr", e, 1'b1);
        e = '0; e.mem_req = 1; e.mem_write = 1; e.iord = 1; e.reg2loc = 1;
        step("st_wr_wait", e, 1'b0);
        #2;
        check("st_write_before_reset", 32'(bus.mem_write), 32'h1);
        reset = 1'b0;
        #1;
        check("st_write_async_drop", 32'(bus.mem_write), 32'h0);
        check("st_ctl_async_zero", cw32(actual()), 32'h0);
        check("st_count_async_zero", instr_count, 32'h0);
        do_reset();
        run_instr(11'h7C0, 1'b0, trapped);
        check("post_reset_store_ok", 32'(trapped), 32'h0);

        // randomized instruction stream against the model
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            logic [10:0] o;
            case ($urandom_range(0, 7))
                0:       o = 11'h7C2;
                1:       o = 11'h7C0;
                2, 3:    o = rlist[$urandom_range(0, 3)];
                4:       o = 11'h5A0 + 11'($urandom_range(0, 7));
                5:       o = 11'h0A0 + 11'($urandom_range(0, 31));
                6:       o = 11'($urandom_range(0, 2047));
                default: o = 11'h7C2;
            endcase
            run_instr(o, 1'($urandom_range(0, 1)), trapped);
            if (trapped) begin
                trap_hold(3);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multicycle LEGv8 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, using one shared memory port for both instructions and data. It handshakes with memory via req/ready, supervises each access with a timeout counter and counts retired instructions. It sits beside the datapath, takes the IR opcode and ALU zero flag, and drives every datapath mux and write enable.

Parameters:
TIMEOUT, 16, max consecutive not-ready cycles per memory access before trap; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
op  in  11  opcode field IR[31:21], stable from DECODE until the instruction completes
alu_zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes the access this cycle (may be combinational, so zero-wait is legal)
mem_req  out  1  memory access request
mem_read  out  1  read strobe, valid with mem_req
mem_write  out  1  write strobe, valid with mem_req
iord  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  PC source: 00 = PC+4, 01 = ALUOut (branch target); 1x reserved
reg2loc  out  1  register-read select
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback select: 1 = MDR
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B input: 00 = register B, 01 = sign-extended immediate, 10 = immediate shifted left by 2
alu_op  out  2  to alu control: 00 = add, 01 = pass B/compare, 10 = funct
fault  out  2  sticky: 00 = none, 01 = illegal opcode, 10 = memory timeout
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset low: state = FETCH, wait counter = 0, instr_count = 0, fault = 00.
- Reset low: all control outputs forced to 0 asynchronously, including a reset that lands mid-access (mem_write drops immediately).
- First mem_req is driven in the first cycle after reset is released.
- Outputs are decoded from state. Exceptions: ir_write and pc_write are qualified by mem_ready where stated, and pc_src in CBZ_EX uses alu_zero (Mealy).
- Any output not listed for a state is 0.
- Opcode decode (11 bits, hex): LDUR 7C2; STUR 7C0; CBZ 5A0-5A7; ADD 458; SUB 658; AND 450; ORR 550; B 0A0-0BF; everything else illegal.
- FETCH: mem_req = 1, mem_read = 1, iord = 0. On mem_ready: ir_write = 1, next DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 10, alu_op = 00 (ALUOut <= branch target).
- DECODE: reg2loc = 1 for STUR/CBZ.
- DECODE next state: LDUR/STUR -> MEM_ADDR; R-type -> EXEC_R; CBZ -> CBZ_EX; B -> B_EX; illegal -> TRAP with fault = 01.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 01, alu_op = 00. Next MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_req = 1, mem_read = 1, iord = 1. On mem_ready -> LD_WB.
- LD_WB: reg_write = 1, mem_to_reg = 1, pc_write = 1, pc_src = 00, retire -> FETCH.
- MEM_WR: mem_req = 1, mem_write = 1, iord = 1, reg2loc = 1. On mem_ready: pc_write = 1, pc_src = 00, retire -> FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> R_WB.
- R_WB: reg_write = 1, pc_write = 1, pc_src = 00, retire -> FETCH.
- CBZ_EX: reg2loc = 1, alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write = 1, pc_src = alu_zero ? 01 : 00, retire -> FETCH.
- B_EX: pc_write = 1, pc_src = 01, retire -> FETCH.
- TRAP: all control outputs 0; held until reset; fault holds its value.
- Latency, zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3. Each not-ready cycle in a memory state adds 1.
- mem_req, mem_read/mem_write and iord stay constant until mem_ready is sampled high. There is no request withdrawal.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR. It increments each cycle in those states with mem_ready = 0.
- Timeout: if TIMEOUT > 0, counter == TIMEOUT-1 and mem_ready = 0, next state is TRAP with fault = 10. So the TIMEOUT-th consecutive not-ready cycle traps.
- A mem_ready arriving in the same cycle as the timeout condition wins (not possible by definition, since the condition requires mem_ready = 0).
- Retire: instr_count increments by 1 in the completing cycle and wraps modulo 2^CNT_W. It does not increment on trap.

Test Plan:
- Op = 458 (ADD), mem_ready = 1 constant -> FETCH, DECODE, EXEC_R, R_WB; reg_write = 1 only in cycle 4 with pc_write = 1, pc_src = 00; instr_count 0 -> 1.
- Op = 7C2 (LDUR), mem_ready low 3 cycles in MEM_RD -> mem_req/mem_read/iord = 1 held 4 cycles; LD_WB in cycle 8 with reg_write = mem_to_reg = 1.
- Op = 5A3 with alu_zero = 1 -> pc_src = 01 in cycle 3; repeat with alu_zero = 0 -> pc_src = 00. Op = 0B7 (B) -> pc_src = 01, no reg/mem writes.
- Op = 7C0 (STUR) -> mem_write = 1 with reg2loc = 1 in MEM_WR, retire on ready; op = 000 -> TRAP, fault = 01, mem_req stays 0 for 20 cycles, instr_count unchanged.
- TIMEOUT = 4, mem_ready held 0 in FETCH -> TRAP after 4 request cycles, fault = 10. Ready on the 4th cycle instead -> normal DECODE.
- Reset pulled low mid MEM_WR -> mem_write = 0 in the same cycle; after release: FETCH request next cycle, instr_count = 0, fault = 00.
